instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Inverse of the core's instruction decode: takes decoded RV32I fields (opcode, func3, func7, register addresses, immediate) and packs them into 32-bit instruction words.
- Streams the packed words, each tagged with a word address, to the instruction-memory write port.
- Used by the program loader and by self-checking benches to build programs from field-level descriptions.
- Valid/ready on both sides; one-entry registered output stage; run/drain/done control FSM.

Parameters:
- ADDR_W, 10: width of the instruction-memory word address.
- BASE_ADDR, 0: first word address written after start.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- start  in  1  one-cycle pulse: begin a new program.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid and in_ready are both high.
- in_last  in  1  bundle is the final instruction of the program.
- in_opcode  in  7  major opcode.
- in_func3  in  3  func3.
- in_func7  in  7  func7 (R-type only).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate as a signed byte offset or value. U-type takes the full upper value, not value >> 12.
- out_valid  out  1  instruction word valid.
- out_ready  in  1  downstream ready.
- out_instr  out  32  packed instruction.
- out_addr  out  ADDR_W  word address for out_instr.
- done  out  1  one-cycle pulse: program fully emitted.
- err_code  out  2  sticky first error: 0 none, 1 illegal opcode, 2 immediate out of range, 3 immediate misaligned or nonzero low bits.
- err_cnt  out  ADDR_W+1  number of rejected bundles.
- instr_cnt  out  ADDR_W+1  number of emitted instructions.

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; out_addr = BASE_ADDR.
- Reset mid-program: discards any held word without emitting it and without done.

FSM states and transitions:
- IDLE: in_ready = 0. On start: clear err_code, err_cnt and instr_cnt; load next address = BASE_ADDR; go to RUN.
- RUN: in_ready = !out_valid | out_ready. On an accepted bundle with in_last = 1, go to DRAIN.
- DRAIN: in_ready = 0. Once the output stage is empty (out_valid = 0, or out_valid & out_ready this cycle), pulse done in the following cycle and go to IDLE.
- start is ignored in RUN and DRAIN.

Encoding of an accepted bundle:
- Format is derived from in_opcode:
  - R: 0110011
  - I: 0000011, 0010011, 1100111
  - S: 0100011
  - B: 1100011
  - J: 1101111
  - U: 0110111, 0010111
- Any other opcode → error 1.
- Fields occupy the standard RV32I bit positions. Unused fields for a format are forced to 0.
- Immediate range checks:
  - I/S: signed 12-bit, else error 2.
  - I-type shifts (opcode 0010011, func3 001/101): shamt = imm[4:0]. imm[11:5] must be 0000000 or 0100000, else error 2.
  - B: signed 13-bit, else error 2; imm[0] must be 0, else error 3.
  - J: signed 21-bit, else error 2; imm[0] must be 0, else error 3.
  - U: imm[11:0] must be 0, else error 3.
- Checks are evaluated in the acceptance cycle.

Valid bundle:
- Registered into the output stage; latency 1 cycle (accept in cycle N → out_valid in cycle N+1).
- out_addr = current address; the address then advances by 1 and wraps modulo 2^ADDR_W.

Errored bundle:
- Consumed but not emitted; address does not advance.
- err_cnt increments.
- err_code latches only if it is currently 0.
- An errored in_last still moves the FSM to DRAIN.

Output stage:
- out_instr and out_addr stay stable while out_valid & !out_ready.
- instr_cnt increments on each out_valid & out_ready.
- Simultaneous accept and output drain in one cycle: full throughput, one word per cycle.
- Counters saturate at the all-ones value.

Decomposition:
- Shared instruction-types include header: opcode constants (R, I load, I jalr, I ALU, S, B, J, LUI, AUIPC), the format enumeration, and the err_code values.
- Natural sub-module: instruction_field_packer. Combinational; takes opcode/fields/imm and returns instr[31:0] plus err[1:0]. Reusable by benches as a golden model.
- The top level keeps the FSM, handshake, output register and counters.

Test Plan:
- Basic encodings: start; stream addi x1,x0,5 / add x3,x1,x2 / sub x3,x1,x2 (func7 0100000) / sw x2,8(x1), with in_last on the fourth → 0x00500093, 0x002081B3, 0x402081B3, 0x0020A423 at addrs 0–3; done one cycle after the last handshake; instr_cnt = 4.
- Branch/jump/upper: beq x1,x2,+8 → 0x00208463; jal x1,+16 → 0x010000EF; lui x5,0x12345000 → 0x123452B7.
- Errors: addi imm 2048 → err_code 2, err_cnt 1, no output, address unchanged. A subsequent beq imm 7 → err_cnt 2, err_code stays 2. Opcode 1111111 → err_cnt 3.
- Backpressure: out_ready held low 3 cycles with in_valid high → in_ready low, out_instr/out_addr stable, no duplicates or losses. Back-to-back traffic with out_ready high → one word per cycle.
- Wrap and boundaries: ADDR_W=2, BASE_ADDR=3, five instructions → addrs 3,0,1,2,3. start pulsed during RUN is ignored. Last bundle errored → done still pulses.
- Reset: rst_n low while out_valid=1 in RUN → all outputs 0 immediately, no done. After release, start restarts at BASE_ADDR with cleared counters.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding constants: major opcodes, instruction formats and error codes.
package instruction_encoder_pkg;

    localparam logic [6:0] OpcodeR      = 7'b0110011;
    localparam logic [6:0] OpcodeLoad   = 7'b0000011;
    localparam logic [6:0] OpcodeJalr   = 7'b1100111;
    localparam logic [6:0] OpcodeAluI   = 7'b0010011;
    localparam logic [6:0] OpcodeStore  = 7'b0100011;
    localparam logic [6:0] OpcodeBranch = 7'b1100011;
    localparam logic [6:0] OpcodeJal    = 7'b1101111;
    localparam logic [6:0] OpcodeLui    = 7'b0110111;
    localparam logic [6:0] OpcodeAuipc  = 7'b0010111;

    typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtJ, FmtU, FmtBad} fmt_e;

    typedef enum logic [1:0] {
        ErrNone   = 2'd0,
        ErrOpcode = 2'd1,
        ErrRange  = 2'd2,
        ErrAlign  = 2'd3
    } err_e;

    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OpcodeR:                            fmt = FmtR;
            OpcodeLoad, OpcodeAluI, OpcodeJalr: fmt = FmtI;
            OpcodeStore:                        fmt = FmtS;
            OpcodeBranch:                       fmt = FmtB;
            OpcodeJal:                          fmt = FmtJ;
            OpcodeLui, OpcodeAuipc:             fmt = FmtU;
            default:                            fmt = FmtBad;
        endcase
        return fmt;
    endfunction

    // True when value is representable as a two's-complement number of the given width.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned bits);
        logic [31:0] upper;
        upper = $unsigned($signed(value) >>> (bits - 1));
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instruction_encoder_field_packer.sv
// Combinational RV32I field packer: builds one instruction word and flags illegal bundles.
module instruction_field_packer
    import instruction_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic [1:0]  err
);

    fmt_e fmt;
    logic is_shift;

    assign fmt      = fmt_of(opcode);
    assign is_shift = (opcode == OpcodeAluI) && ((func3 == 3'b001) || (func3 == 3'b101));

    always_comb begin
        instr = '0;
        err   = ErrNone;
        unique case (fmt)
            FmtR: instr = {func7, rs2, rs1, func3, rd, opcode};
            FmtI: begin
                instr = {imm[11:0], rs1, func3, rd, opcode};
                // Shifts carry shamt in imm[4:0]; only the SRA marker may appear above it.
                if (is_shift) begin
                    if ((imm[11:5] != 7'b0000000) && (imm[11:5] != 7'b0100000)) err = ErrRange;
                end else if (!fits_signed(imm, 12)) begin
                    err = ErrRange;
                end
            end
            FmtS: begin
                instr = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
                if (!fits_signed(imm, 12)) err = ErrRange;
            end
            FmtB: begin
                instr = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
                if (!fits_signed(imm, 13)) err = ErrRange;
                else if (imm[0]) err = ErrAlign;
            end
            FmtJ: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (!fits_signed(imm, 21)) err = ErrRange;
                else if (imm[0]) err = ErrAlign;
            end
            FmtU: begin
                instr = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'h000) err = ErrAlign;
            end
            default: err = ErrOpcode;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streams packed RV32I words with word addresses to an instruction-memory write port.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_func3,
    input  logic [6:0]        in_func7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W:0]   instr_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CntMax   = '1;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W:0]   instr_cnt_q, instr_cnt_d;

    logic [31:0] packed_instr;
    logic [1:0]  pack_err;
    logic        accept;
    logic        drain;

    instruction_field_packer u_packer (
        .opcode (in_opcode),
        .func3  (in_func3),
        .func7  (in_func7),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .instr  (packed_instr),
        .err    (pack_err)
    );

    assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        addr_d      = addr_q;
        done_d      = 1'b0;
        err_code_d  = err_code_q;
        err_cnt_d   = err_cnt_q;
        instr_cnt_d = instr_cnt_q;

        if (drain) begin
            out_valid_d = 1'b0;
            if (instr_cnt_q != CntMax) instr_cnt_d = instr_cnt_q + CntOne;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRun;
                    err_code_d  = ErrNone;
                    err_cnt_d   = '0;
                    instr_cnt_d = '0;
                    addr_d      = BaseAddr;
                end
            end
            StRun: begin
                if (accept) begin
                    if (pack_err == ErrNone) begin
                        out_valid_d = 1'b1;
                        out_instr_d = packed_instr;
                        out_addr_d  = addr_q;
                        addr_d      = addr_q + AddrOne;
                    end else begin
                        if (err_cnt_q != CntMax) err_cnt_d = err_cnt_q + CntOne;
                        if (err_code_q == ErrNone) err_code_d = pack_err;
                    end
                    if (in_last) state_d = StDrain;
                end
            end
            StDrain: begin
                if (!out_valid_q || drain) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BaseAddr;
            addr_q      <= BaseAddr;
            done_q      <= 1'b0;
            err_code_q  <= ErrNone;
            err_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign done      = done_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench: table of hand-encoded bundles plus throughput, wrap, stall and reset sequences.
module tb_instruction_encoder;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        last;
        logic [31:0] exp_instr;
        logic [1:0]  exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_func3 = '0;
    logic [6:0]  in_func7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;

    logic        in_ready0, out_valid0, done0;
    logic [31:0] out_instr0;
    logic [9:0]  out_addr0;
    logic [1:0]  err_code0;
    logic [10:0] err_cnt0, instr_cnt0;

    logic        in_ready1, out_valid1, done1;
    logic [31:0] out_instr1;
    logic [1:0]  out_addr1;
    logic [1:0]  err_code1;
    logic [2:0]  err_cnt1, instr_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [31:0] q_instr[$];
    int          q_addr0[$];
    int          q_addr1[$];
    int          q_cyc[$];

    vec_t tbl[16];
    vec_t prog[5];

    instruction_encoder u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
        .in_last(in_last), .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid0), .out_ready(out_ready), .out_instr(out_instr0),
        .out_addr(out_addr0), .done(done0), .err_code(err_code0), .err_cnt(err_cnt0),
        .instr_cnt(instr_cnt0)
    );

    instruction_encoder #(.ADDR_W(2), .BASE_ADDR(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1),
        .out_addr(out_addr1), .done(done1), .err_code(err_code1), .err_cnt(err_cnt1),
        .instr_cnt(instr_cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_valid0 && out_ready) begin
            q_instr.push_back(out_instr0);
            q_addr0.push_back(int'(out_addr0));
            q_cyc.push_back(cyc);
        end
        if (out_valid1 && out_ready) q_addr1.push_back(int'(out_addr1));
        if (done0) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic last, input logic [31:0] exp_instr,
                                input logic [1:0] exp_err);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.last = last; v.exp_instr = exp_instr; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_opcode = v.op; in_func3 = v.f3; in_func7 = v.f7;
        in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
        in_last = v.last;
        in_valid = 1'b1;
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic wait_accept(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " accepted"}, {31'b0, in_ready0}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string name, output int when);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 40);
        check({name, " done"}, {31'b0, done0}, 32'd1);
        when = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int exp_addr, exp_ecnt, exp_ecode, n_valid, dcyc, dc;

        tbl[0]  = mk(7'h13, 3'd0, 7'h7f, 5'd1, 5'd0, 5'd9, 32'd5,         1'b0, 32'h00500093, 2'd0);
        tbl[1]  = mk(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hffffffff,  1'b0, 32'h002081B3, 2'd0);
        tbl[2]  = mk(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,         1'b0, 32'h402081B3, 2'd0);
        tbl[3]  = mk(7'h23, 3'd2, 7'h7f, 5'd31, 5'd1, 5'd2, 32'd8,        1'b0, 32'h0020A423, 2'd0);
        tbl[4]  = mk(7'h63, 3'd0, 7'h00, 5'd7, 5'd1, 5'd2, 32'd8,         1'b0, 32'h00208463, 2'd0);
        tbl[5]  = mk(7'h6f, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd16,        1'b0, 32'h010000EF, 2'd0);
        tbl[6]  = mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,  1'b0, 32'h123452B7, 2'd0);
        tbl[7]  = mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      1'b0, 32'h0, 2'd2);
        tbl[8]  = mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7,         1'b0, 32'h0, 2'd3);
        tbl[9]  = mk(7'h7f, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0,         1'b0, 32'h0, 2'd1);
        tbl[10] = mk(7'h13, 3'd5, 7'h00, 5'd1, 5'd1, 5'd0, 32'h405,       1'b0, 32'h4050D093, 2'd0);
        tbl[11] = mk(7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'h45,        1'b0, 32'h0, 2'd2);
        tbl[12] = mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hfffff800,  1'b0, 32'h80000093, 2'd0);
        tbl[13] = mk(7'h17, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'hfffff000,  1'b0, 32'hFFFFF117, 2'd0);
        tbl[14] = mk(7'h6f, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hfffffffc,  1'b0, 32'hFFDFF06F, 2'd0);
        tbl[15] = mk(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001,  1'b1, 32'h0, 2'd3);

        // Reset state
        out_ready = 1'b1;
        #12;
        check("rst in_ready", {31'b0, in_ready0}, 32'd0);
        check("rst out_valid", {31'b0, out_valid0}, 32'd0);
        check("rst out_instr", out_instr0, 32'd0);
        check("rst out_addr", 32'(out_addr0), 32'd0);
        check("rst out_addr wrap dut", 32'(out_addr1), 32'd3);
        check("rst done", {31'b0, done0}, 32'd0);
        check("rst err_code", 32'(err_code0), 32'd0);
        check("rst err_cnt", 32'(err_cnt0), 32'd0);
        check("rst instr_cnt", 32'(instr_cnt0), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: one bundle at a time, checked one cycle after acceptance
        pulse_start();
        exp_addr = 0; exp_ecnt = 0; exp_ecode = 0; n_valid = 0;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            wait_accept($sformatf("vec%0d", i));
            @(negedge clk);
            if (tbl[i].exp_err == 2'd0) begin
                check($sformatf("vec%0d out_valid", i), {31'b0, out_valid0}, 32'd1);
                check($sformatf("vec%0d out_instr", i), out_instr0, tbl[i].exp_instr);
                check($sformatf("vec%0d out_addr", i), 32'(out_addr0), 32'(exp_addr));
                exp_addr++;
                n_valid++;
            end else begin
                check($sformatf("vec%0d no output", i), {31'b0, out_valid0}, 32'd0);
                exp_ecnt++;
                if (exp_ecode == 0) exp_ecode = int'(tbl[i].exp_err);
            end
            check($sformatf("vec%0d err_cnt", i), 32'(err_cnt0), 32'(exp_ecnt));
            check($sformatf("vec%0d err_code", i), 32'(err_code0), 32'(exp_ecode));
            @(posedge clk);
            #1;
        end
        wait_done("table", dcyc);
        check("table instr_cnt", 32'(instr_cnt0), 32'(n_valid));
        check("table err_cnt", 32'(err_cnt0), 32'd5);
        check("table instr_cnt saturated", 32'(instr_cnt1), 32'd7);
        check("table err_cnt small", 32'(err_cnt1), 32'd5);

        // Back-to-back program: throughput, address wrap, done timing, cleared counters
        for (int i = 0; i < 5; i++) prog[i] = tbl[i];
        prog[4].last = 1'b1;
        q_instr.delete(); q_addr0.delete(); q_addr1.delete(); q_cyc.delete();
        pulse_start();
        check("restart err_cnt cleared", 32'(err_cnt0), 32'd0);
        check("restart err_code cleared", 32'(err_code0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(prog[i]);
            wait_accept($sformatf("b2b%0d", i));
        end
        wait_done("b2b", dcyc);
        check("b2b count", 32'(q_instr.size()), 32'd5);
        if (q_instr.size() == 5 && q_addr1.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("b2b%0d instr", i), q_instr[i], prog[i].exp_instr);
                check($sformatf("b2b%0d addr", i), 32'(q_addr0[i]), 32'(i));
                check($sformatf("b2b%0d wrap addr", i), 32'(q_addr1[i]), 32'((i + 3) % 4));
            end
            check("b2b one per cycle", 32'(q_cyc[4] - q_cyc[0]), 32'd4);
            check("b2b done timing", 32'(dcyc), 32'(q_cyc[4] + 1));
        end
        check("b2b instr_cnt", 32'(instr_cnt0), 32'd5);

        // Backpressure with start pulsed mid-program
        q_instr.delete(); q_addr0.delete(); q_addr1.delete(); q_cyc.delete();
        pulse_start();
        out_ready = 1'b0;
        drive(tbl[0]);
        wait_accept("bp0");
        drive(tbl[1]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp stall%0d in_ready", k), {31'b0, in_ready0}, 32'd0);
            check($sformatf("bp stall%0d out_valid", k), {31'b0, out_valid0}, 32'd1);
            check($sformatf("bp stall%0d out_instr", k), out_instr0, 32'h00500093);
            check($sformatf("bp stall%0d out_addr", k), 32'(out_addr0), 32'd0);
            @(posedge clk);
            #1;
            start = (k == 0);
        end
        out_ready = 1'b1;
        wait_accept("bp1");
        prog[0] = tbl[2];
        prog[0].last = 1'b1;
        drive(prog[0]);
        wait_accept("bp2");
        wait_done("bp", dcyc);
        check("bp count", 32'(q_instr.size()), 32'd3);
        if (q_instr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp%0d instr", i), q_instr[i], tbl[i].exp_instr);
                check($sformatf("bp%0d addr", i), 32'(q_addr0[i]), 32'(i));
            end
        end
        check("bp instr_cnt", 32'(instr_cnt0), 32'd3);

        // Asynchronous reset while a word is held
        q_instr.delete(); q_addr0.delete(); q_addr1.delete(); q_cyc.delete();
        pulse_start();
        out_ready = 1'b0;
        drive(tbl[0]);
        wait_accept("rst0");
        @(negedge clk);
        check("held before reset", {31'b0, out_valid0}, 32'd1);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid0}, 32'd0);
        check("async rst out_instr", out_instr0, 32'd0);
        check("async rst out_addr", 32'(out_addr0), 32'd0);
        check("async rst out_addr wrap dut", 32'(out_addr1), 32'd3);
        check("async rst in_ready", {31'b0, in_ready0}, 32'd0);
        check("async rst instr_cnt", 32'(instr_cnt0), 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no done after reset", 32'(done_cnt), 32'(dc));
        check("held word discarded", 32'(q_instr.size()), 32'd0);
        pulse_start();
        prog[0] = tbl[1];
        prog[0].last = 1'b1;
        drive(prog[0]);
        wait_accept("post rst");
        @(negedge clk);
        check("post rst out_instr", out_instr0, 32'h002081B3);
        check("post rst out_addr", 32'(out_addr0), 32'd0);
        check("post rst wrap out_addr", 32'(out_addr1), 32'd3);
        wait_done("post rst", dcyc);
        check("post rst instr_cnt", 32'(instr_cnt0), 32'd1);
        check("post rst err_cnt", 32'(err_cnt0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
